// File: rtl/yrv_uart_pkg.sv
// Shared types for the yrv UART receiver.
// States, byte type and default divisor.
package yrv_uart_pkg;

  localparam int DEF_BAUD_DIV = 868;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

endpackage

// File: rtl/yrv_uart_fifo.sv
// Synchronous show-ahead FIFO for received bytes.
// Head is presented combinationally on rdata.
module yrv_uart_fifo
  import yrv_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  byte_t          mem_q [DEPTH];
  byte_t          mem_d [DEPTH];
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           do_push;
  logic           do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = empty ? 8'h00 : mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/yrv_uart_rx.sv
// 8N1 serial receiver with mid-bit sampling and show-ahead FIFO.
// Define YRV_UART_RX_PARITY_EN for 8E1 frames with parity checking.
module yrv_uart_rx
  import yrv_uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEF_BAUD_DIV,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam logic [15:0] FULL_LD = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LD = 16'(BAUD_DIV / 2 - 1);

  logic         sync1_q, sync2_q;
  logic         rxd_s;
  state_t       state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [2:0]   idx_q, idx_d;
  byte_t        data_q, data_d;
  logic         expire;
  logic         push;
  logic         full;
  logic         empty;
`ifdef YRV_UART_RX_PARITY_EN
  logic         par_q, par_d;
`endif

  assign rxd_s  = sync2_q;
  assign expire = (cnt_q == '0);
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    push       = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
`ifdef YRV_UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    if (state_q != IDLE && state_q != BREAK && !expire) begin
      cnt_d = cnt_q - 16'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          cnt_d   = HALF_LD;
          state_d = START;
        end
      end
      START: begin
        if (expire) begin
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            cnt_d   = FULL_LD;
            idx_d   = 3'd0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (expire) begin
          data_d[idx_q] = rxd_s;
          cnt_d         = FULL_LD;
          idx_d         = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef YRV_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef YRV_UART_RX_PARITY_EN
      PARITY: begin
        if (expire) begin
          par_d   = rxd_s;
          cnt_d   = FULL_LD;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (expire) begin
`ifdef YRV_UART_RX_PARITY_EN
          parity_err = par_q ^ (^data_q);
`endif
          // A bad stop bit means the line may still be low: wait it out.
          if (rxd_s) begin
            push    = ~parity_err;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun  = push & full & ~rd_en;
  assign rd_valid = ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef YRV_UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef YRV_UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  yrv_uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (data_q),
    .pop   (rd_en),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_yrv_uart_rx.sv
// Scoreboard bench for yrv_uart_rx (BAUD_DIV=8, FIFO_DEPTH=4).
// Expected bytes are queued as frames are sent and popped on reads.
module tb_yrv_uart_rx;

  localparam int BAUD  = 8;
  localparam int DEPTH = 4;
  localparam int SJ    = BAUD / 2 + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;

  int n_chk  = 0;
  int n_pass = 0;
  int m_cnt  = 0;
  int fe_n = 0, ov_n = 0, pe_n = 0;
  int fe_x = 0, ov_x = 0, pe_x = 0;
  bit busy_seen = 0;
  logic [7:0] q[$];

  yrv_uart_rx #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err)  fe_n++;
    if (overrun)    ov_n++;
    if (parity_err) pe_n++;
    if (busy)       busy_seen = 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b,
                      input logic par_ok, input logic pop_at_stop);
    bit good, accept;
    int nw;
    good   = stop_b && par_ok;
    accept = good && (pop_at_stop || m_cnt < DEPTH);
    nw     = m_cnt - (pop_at_stop && m_cnt > 0 ? 1 : 0) + (accept ? 1 : 0);
    if (good && !accept) ov_x++;
    if (!stop_b) fe_x++;
    if (!par_ok) pe_x++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef YRV_UART_RX_PARITY_EN
    drive_bit(par_ok ? ^d : ~(^d));
`endif
    rxd = stop_b;
    for (int j = 1; j <= BAUD; j++) begin
      @(negedge clk);
      if (j == SJ) begin
        chk("count_pre", 32'(fifo_count), m_cnt);
        if (pop_at_stop) begin
          chk("head_at_stop", 32'(rd_data), 32'(q.pop_front()));
          rd_en = 1'b1;
        end
      end
      if (j == SJ + 1) begin
        rd_en = 1'b0;
        chk("count_post", 32'(fifo_count), nw);
        chk("valid_post", 32'(rd_valid), (nw != 0) ? 1 : 0);
        if (accept) q.push_back(d);
        m_cnt = nw;
      end
    end
  endtask

  task automatic pop_one();
    logic [7:0] e;
    @(negedge clk);
    chk("rd_valid", 32'(rd_valid), 1);
    e = (q.size() > 0) ? q.pop_front() : 8'h00;
    chk("rd_data", 32'(rd_data), 32'(e));
    rd_en = 1'b1;
    m_cnt--;
    @(negedge clk);
    rd_en = 1'b0;
    chk("count_pop", 32'(fifo_count), m_cnt);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(rd_valid), 0);
    chk({tag, "_data"},  32'(rd_data), 0);
    chk({tag, "_count"}, 32'(fifo_count), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_ferr"},  32'(frame_err), 0);
    chk({tag, "_ovr"},   32'(overrun), 0);
    chk({tag, "_perr"},  32'(parity_err), 0);
  endtask

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    idle(16);

    send(8'h55, 1'b1, 1'b1, 1'b0);
    idle(16);
    send(8'hA3, 1'b1, 1'b1, 1'b0);
    idle(16);
    pop_one();
    pop_one();

    busy_seen = 0;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    idle(24);
    chk("glitch_busy_seen", 32'(busy_seen), 1);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_count", 32'(fifo_count), 0);
    chk("glitch_ferr", fe_n, fe_x);
    chk("glitch_perr", pe_n, pe_x);

    send(8'h3C, 1'b0, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    idle(24);
    chk("break_ferr", fe_n, fe_x);
    chk("break_busy", 32'(busy), 0);
    chk("break_count", 32'(fifo_count), 0);
    send(8'h81, 1'b1, 1'b1, 1'b0);
    idle(16);
    pop_one();

    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1'b1, 1'b1, 1'b0);
      idle(16);
    end
    chk("ovr_count", ov_n, ov_x);
    chk("ovr_full", 32'(fifo_count), DEPTH);

    send(8'h77, 1'b1, 1'b1, 1'b1);
    idle(16);
    chk("pushpop_ovr", ov_n, ov_x);
    chk("pushpop_count", 32'(fifo_count), DEPTH);
    pop_one();
    pop_one();
    pop_one();

    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rxd   = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    q.delete();
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    idle(24);
    chk("midrst_idle_count", 32'(fifo_count), 0);
    send(8'h12, 1'b1, 1'b1, 1'b0);
    idle(16);
    pop_one();

`ifdef YRV_UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 1'b0);
    idle(16);
    chk("par_count", 32'(fifo_count), 0);
    chk("par_perr", pe_n, pe_x);
`endif

    chk("final_ferr", fe_n, fe_x);
    chk("final_ovr", ov_n, ov_x);
    chk("final_perr", pe_n, pe_x);
    chk("final_q_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
